pw_stream_deframer: RTL and testbench

- Avalon-ST sink at the input of the hash test core.
- Collects three 16-bit password words on channel 0, most significant word first.
- A channel-1 beat commits the collected words as one 48-bit candidate, which is presented on a valid/ready source port to the hash pipeline.
- Malformed framing (short frame, overlong frame) is detected, counted and discarded.

---
 rtl/pw_stream_deframer.sv | 81 ++++++++
 tb/tb_pw_stream_deframer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_stream_deframer.sv
// rtl/pw_stream_deframer.sv - collects channel-0 words into a candidate password, committed by a channel-1 beat
module pw_stream_deframer #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 3,
    parameter int ERR_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_channel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W*WORDS-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ERR_W-1:0]         short_cnt,
    output logic [ERR_W-1:0]         long_cnt
);

    localparam int OUT_W = DATA_W * WORDS;
    localparam int CNT_W = $clog2(WORDS + 1);

    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [OUT_W-1:0] sr;

    logic full;
    logic accept;
    logic word_beat;
    logic mark_beat;
    logic commit;

    assign full      = (cnt == CNT_W'(WORDS));
    // Stall only when a complete frame has nowhere to go; never looks at the input side.
    assign in_ready  = !(out_valid && full);
    assign accept    = in_valid && in_ready;
    assign word_beat = accept && !in_channel;
    assign mark_beat = accept && in_channel;
    assign commit    = mark_beat && full && !ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            ovf       <= 1'b0;
            sr        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            short_cnt <= '0;
            long_cnt  <= '0;
        end else begin
            if (word_beat) begin
                if (!full) begin
                    sr  <= OUT_W'({sr, in_data});
                    cnt <= cnt + 1'b1;
                end else begin
                    ovf <= 1'b1;
                    if (long_cnt != '1) begin
                        long_cnt <= long_cnt + 1'b1;
                    end
                end
            end

            // A marker on an empty frame is an idle/resync beat and changes nothing.
            if (mark_beat && (cnt != '0)) begin
                cnt <= '0;
                ovf <= 1'b0;
                if (!full && (short_cnt != '1)) begin
                    short_cnt <= short_cnt + 1'b1;
                end
            end

            if (commit) begin
                out_data  <= sr;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pw_stream_deframer.sv
// tb/tb_pw_stream_deframer.sv - directed self-checking bench for pw_stream_deframer
module tb_pw_stream_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_channel;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  short_cnt;
    logic [7:0]  long_cnt;

    int checks = 0;
    int failures = 0;

    logic [47:0] got[$];
    logic        watch_ready = 1'b0;
    int          ready_lows = 0;

    pw_stream_deframer #(.DATA_W(16), .WORDS(3), .ERR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_channel (in_channel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .short_cnt  (short_cnt),
        .long_cnt   (long_cnt)
    );

    always #5 clk = ~clk;

    // Record every output handshake that will complete at the coming edge.
    always @(negedge clk) begin
        if (out_valid && out_ready && !reset) got.push_back(out_data);
        if (watch_ready && !in_ready) ready_lows++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic ch, input logic [15:0] d);
        int waited;
        waited = 0;
        in_valid   = 1'b1;
        in_channel = ch;
        in_data    = d;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 50) begin
                checks++;
                failures++;
                $error("FAIL send_timeout observed=stalled expected=accept data=%h", d);
                break;
            end
        end
        in_valid   = 1'b0;
        in_channel = 1'b0;
        in_data    = 16'h0;
    endtask

    task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        send(1'b0, a);
        send(1'b0, b);
        send(1'b0, c);
        send(1'b1, 16'hxxxx);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic check_got(input string tag, input int idx, input logic [47:0] exp);
        logic [47:0] v;
        v = (idx < got.size()) ? got[idx] : 48'hxxxx_xxxx_xxxx;
        check(tag, {16'h0, v}, {16'h0, exp});
    endtask

    initial begin
        reset      = 1'b1;
        in_data    = 16'h0;
        in_channel = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_short", 64'(short_cnt), 64'd0);
        check("rst_long", 64'(long_cnt), 64'd0);

        // Basic: idle marker, then one frame; out_valid the cycle after commit
        got.delete();
        send(1'b1, 16'hxxxx);
        check("idle_no_out", 64'(out_valid), 64'd0);
        send(1'b0, 16'hABCD);
        send(1'b0, 16'hEF01);
        send(1'b0, 16'h2345);
        check("basic_pre_commit", 64'(out_valid), 64'd0);
        send(1'b1, 16'hxxxx);
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_data", 64'(out_data), 64'hABCDEF012345);
        step(1);
        check("basic_cleared", 64'(out_valid), 64'd0);
        check("basic_short", 64'(short_cnt), 64'd0);
        check("basic_long", 64'(long_cnt), 64'd0);
        check("basic_count", 64'(got.size()), 64'd1);

        // Back-to-back frames with continuous valid
        got.delete();
        watch_ready = 1'b1;
        frame(16'h4949, 16'hB5DE, 16'h9601);
        frame(16'h55AA, 16'h6633, 16'h0100);
        frame(16'h0004, 16'hA53C, 16'hF15B);
        frame(16'hABCD, 16'hEF01, 16'h2345);
        step(2);
        watch_ready = 1'b0;
        check("bb_count", 64'(got.size()), 64'd4);
        check_got("bb_0", 0, 48'h4949B5DE9601);
        check_got("bb_1", 1, 48'h55AA66330100);
        check_got("bb_2", 2, 48'h0004A53CF15B);
        check_got("bb_3", 3, 48'hABCDEF012345);
        check("bb_ready_lows", 64'(ready_lows), 64'd0);

        // Backpressure: second frame fills, sink stalls, drains in order
        got.delete();
        out_ready = 1'b0;
        frame(16'h1111, 16'h2222, 16'h3333);
        check("bp_valid1", 64'(out_valid), 64'd1);
        send(1'b0, 16'h4444);
        send(1'b0, 16'h5555);
        check("bp_ready_mid", 64'(in_ready), 64'd1);
        send(1'b0, 16'h6666);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        step(3);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_data", 64'(out_data), 64'h111122223333);
        check("bp_still_low", 64'(in_ready), 64'd0);
        in_valid   = 1'b1;
        in_channel = 1'b1;
        out_ready  = 1'b1;
        step(1);
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_resume", 64'(in_ready), 64'd1);
        step(1);
        in_valid   = 1'b0;
        in_channel = 1'b0;
        check("bp_valid2", 64'(out_valid), 64'd1);
        check("bp_data2", 64'(out_data), 64'h444455556666);
        step(2);
        check("bp_count", 64'(got.size()), 64'd2);
        check_got("bp_0", 0, 48'h111122223333);
        check_got("bp_1", 1, 48'h444455556666);

        // Short frame
        got.delete();
        send(1'b0, 16'h1234);
        send(1'b1, 16'hxxxx);
        check("short_no_out", 64'(out_valid), 64'd0);
        check("short_cnt1", 64'(short_cnt), 64'd1);
        frame(16'h0A0B, 16'h0C0D, 16'h0E0F);
        check("short_next_data", 64'(out_data), 64'h0A0B0C0D0E0F);
        check("short_next_valid", 64'(out_valid), 64'd1);
        step(1);

        // Overlong frame
        got.delete();
        send(1'b0, 16'hAAAA);
        send(1'b0, 16'hBBBB);
        send(1'b0, 16'hCCCC);
        send(1'b0, 16'hDDDD);
        check("long_cnt_word", 64'(long_cnt), 64'd1);
        send(1'b1, 16'hxxxx);
        check("long_no_out", 64'(out_valid), 64'd0);
        check("long_cnt1", 64'(long_cnt), 64'd1);
        check("long_short_kept", 64'(short_cnt), 64'd1);
        frame(16'h0001, 16'h0002, 16'h0003);
        check("long_next_valid", 64'(out_valid), 64'd1);
        check("long_next_data", 64'(out_data), 64'h000100020003);
        step(2);
        check("long_count", 64'(got.size()), 64'd1);

        // Reset mid-frame
        got.delete();
        send(1'b0, 16'hDEAD);
        send(1'b0, 16'hBEEF);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mrst_ready", 64'(in_ready), 64'd1);
        check("mrst_short", 64'(short_cnt), 64'd0);
        check("mrst_long", 64'(long_cnt), 64'd0);
        frame(16'h0004, 16'hA53C, 16'hF15B);
        check("mrst_valid", 64'(out_valid), 64'd1);
        check("mrst_data", 64'(out_data), 64'h0004A53CF15B);
        check("mrst_short2", 64'(short_cnt), 64'd0);
        check("mrst_long2", 64'(long_cnt), 64'd0);
        step(2);
        check("mrst_count", 64'(got.size()), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
